// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    generate
        if (DEPTH < 32'sd2 || (DEPTH & (DEPTH - 32'sd1)) != 32'sd0) begin : g_bad_depth
            $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 2");
        end
        if (AF_THRESH < 32'sd1 || AF_THRESH > DEPTH) begin : g_bad_af
            $fatal(1, "sync_fifo_param: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 32'sd0 || AE_THRESH > DEPTH - 32'sd1) begin : g_bad_ae
            $fatal(1, "sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
        end
        if (DATA_W < 32'sd1) begin : g_bad_dw
            $fatal(1, "sync_fifo_param: DATA_W must be >= 1");
        end
    endgenerate

    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF    = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0]   CNT_AE    = (AW + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic [AW:0]       count_next_s;
    logic              full_r;
    logic              empty_r;
    logic              af_r;
    logic              ae_r;
    logic              ovf_r;
    logic              udf_r;
    logic              wr_acc_s;
    logic              rd_acc_s;

    // Accept decisions use only registered flags; occupancy follows the accepted ops
    always_comb begin
        wr_acc_s     = wr_en && !full_r;
        rd_acc_s     = rd_en && !empty_r;
        count_next_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and status flags (flags pre-decoded so outputs come straight from flops)
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            af_r     <= 1'b0;
            ae_r     <= 1'b1;
        end else begin
            if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (rd_acc_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_DEPTH);
            empty_r <= (count_next_s == '0);
            af_r    <= (count_next_s >= CNT_AF);
            ae_r    <= (count_next_s <= CNT_AE);
        end
    end

    // Sticky error flags; a new error event takes priority over a clear
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (wr_en && full_r)  ovf_r <= 1'b1;
            else if (err_clr)     ovf_r <= 1'b0;
            if (rd_en && empty_r) udf_r <= 1'b1;
            else if (err_clr)     udf_r <= 1'b0;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc_s) mem_r[wr_ptr_r] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem_r[rd_ptr_r];
    assign rd_valid = !empty_r;
`else
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;

    // Registered read port: data lands one cycle after the pop, valid pulses for that cycle
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) rd_data_r <= mem_r[rd_ptr_r];
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
`endif

    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign count        = count_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule
